hack_run_controller: RTL and testbench
======================================

Name: hack_run_controller

Overview:
Run-sequencing controller for the Hack computer (CPU + instruction ROM + data RAM).
- On a start request it pulses the computer's memory reload, then holds the CPU in reset, then clock-enables execution.
- Execution stops on one of: breakpoint PC, tight-loop (program END) detection, cycle budget, or abort.
- Used by benches and the board-level debug shell to run a loaded program and report why and when it stopped.

Parameters:
CYC_W, 32, width of cycle budget and executed-instruction counter
RESET_CYCLES, 1, number of cycles cpu_reset is held high (>=1)
LOOP_HITS, 4, consecutive loop-signature matches that declare a halt loop (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high controller reset
start  input  1  begin a run; sampled only in IDLE or DONE
abort  input  1  stop the current run immediately
max_cycles  input  CYC_W  instruction budget; 0 = unlimited
bp_en  input  1  breakpoint enable
bp_addr  input  15  breakpoint PC
loop_en  input  1  halt-loop detection enable
pc  input  15  computer PC (address of instruction about to execute)
cpu_reload  output  1  one-cycle memory/program reload pulse
cpu_reset  output  1  CPU reset
cpu_en  output  1  CPU clock enable; the instruction at pc executes on an edge where cpu_en=1
busy  output  1  high in LOAD, RST, RUN
done  output  1  high in DONE
stop_cause  output  2  0 abort, 1 budget, 2 breakpoint, 3 loop; valid while done=1
cycles  output  CYC_W  instructions executed in the current/last run

Behaviour:
- Reset values: state IDLE, cycles 0, stop_cause 0, pc history invalid, loop counter 0, all 1-bit outputs 0. Controller reset does not assert cpu_reset.
- Registered outputs: cpu_reload, cpu_reset, busy, done, stop_cause, cycles. cpu_en is combinational (state plus stop_now).
- IDLE/DONE: start=1 -> LOAD; clear cycles, loop counter and pc history. In DONE, done, stop_cause and cycles hold until start.
- LOAD: cpu_reload=1 for exactly 1 cycle -> RST.
- RST: cpu_reset=1 and cpu_en=1 for RESET_CYCLES cycles, so the CPU reset is clocked in -> RUN.
- RUN: stop_now is evaluated on the current pc with priority abort > breakpoint (bp_en && pc==bp_addr) > loop > budget (max_cycles!=0 && cycles==max_cycles).
  - stop_now=0: cpu_en=1, cycles+=1 (saturates at all-ones), push pc into history (pc_d1 <- pc, pc_d2 <- pc_d1).
  - stop_now=1: cpu_en=0 in that same cycle, so the stopping instruction is NOT executed; next state DONE, latch stop_cause.
- Loop detection (loop_en=1):
  - A match is pc==pc_d2, with pc_d2 valid (at least 2 instructions executed this run).
  - Loop counter increments on a match and clears on a non-match.
  - Loop stop fires when a match occurs with counter==LOOP_HITS-1.
  - Heuristic; may fire on single-instruction countdown loops. Software disables it for those.
- Budget: exactly max_cycles instructions execute. max_cycles=0 runs until another cause; the saturated counter does not stop the run.
- Abort in LOAD or RST: -> DONE, cause 0, cpu_reset/cpu_reload drop next cycle, cycles=0. Abort in IDLE/DONE: ignored.
- start while busy: ignored. start and abort together in DONE: start wins.
- Breakpoint at pc=0 stops on the first RUN cycle with cycles=0.
- reset mid-run: IDLE next edge, all outputs to reset values, cpu_en=0 in the cycle reset is sampled.

Test Plan:
- max program, RAM[0]=3, RAM[1]=5, bp_en=1, bp_addr=14, max_cycles=0 -> done, stop_cause=2, cycles=12, RAM[2]=5, cpu_en=0 while pc=14.
- Same program, loop_en=1, bp_en=0 -> stop_cause=3, cycles=17, RAM[2]=5.
- Reload RAM[0]=23456, RAM[1]=12345, loop_en=1, second start -> LOAD 1 cycle, RST 1 cycle, then stop_cause=3, cycles=15, RAM[2]=23456.
- max_cycles=5, no bp/loop -> stop_cause=1, cycles=5, pc=5; start again -> cycles restarts at 0, reload pulse seen.
- abort asserted in the 3rd RUN cycle -> stop_cause=0, cycles=2; abort during RST -> cycles=0, cpu_reset low next cycle.
- reset asserted during RUN (with start held) -> next edge: busy=0, done=0, cpu_en=0, cycles=0; start accepted the following cycle.

Source files
------------

// File: rtl/hack_run_controller.sv
// Run sequencer for the Hack computer: reload, hold the CPU in reset, then clock-enable
// execution until abort, breakpoint, halt-loop or instruction budget stops it.
module hack_run_controller #(
   parameter int CYC_W        = 32,
   parameter int RESET_CYCLES = 1,
   parameter int LOOP_HITS    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CYC_W-1:0] max_cycles,
   input  logic             bp_en,
   input  logic [14:0]      bp_addr,
   input  logic             loop_en,
   input  logic [14:0]      pc,
   output logic             cpu_reload,
   output logic             cpu_reset,
   output logic             cpu_en,
   output logic             busy,
   output logic             done,
   output logic [1:0]       stop_cause,
   output logic [CYC_W-1:0] cycles
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_RST  = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam int RC_W = $clog2(RESET_CYCLES + 1);
   localparam int LH_W = $clog2(LOOP_HITS + 1);

   logic [2:0]       state_q, state_d;
   logic [CYC_W-1:0] cycles_q, cycles_d;
   logic [1:0]       cause_q, cause_d;
   logic [14:0]      pc_d1_q, pc_d1_d, pc_d2_q, pc_d2_d;
   logic [1:0]       hist_q, hist_d;
   logic [LH_W-1:0]  loop_cnt_q, loop_cnt_d;
   logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic             cpu_reload_q, cpu_reset_q, busy_q, done_q;

   logic       bp_hit, loop_match, loop_hit, budget_hit, stop_now;
   logic [1:0] cause_now;

   // Stop decision on the pc about to execute, abort > breakpoint > loop > budget.
   always_comb begin
      bp_hit     = bp_en && (pc == bp_addr);
      loop_match = loop_en && (hist_q == 2'd2) && (pc == pc_d2_q);
      loop_hit   = loop_match && (loop_cnt_q == LH_W'(LOOP_HITS - 1));
      budget_hit = (max_cycles != '0) && (cycles_q == max_cycles);
      stop_now   = abort || bp_hit || loop_hit || budget_hit;
      if (abort)         cause_now = 2'd0;
      else if (bp_hit)   cause_now = 2'd2;
      else if (loop_hit) cause_now = 2'd3;
      else               cause_now = 2'd1;
   end

   assign cpu_en = !reset && (((state_q == S_RST) && !abort) ||
                              ((state_q == S_RUN) && !stop_now));

   always_comb begin
      state_d    = state_q;
      cycles_d   = cycles_q;
      cause_d    = cause_q;
      pc_d1_d    = pc_d1_q;
      pc_d2_d    = pc_d2_q;
      hist_d     = hist_q;
      loop_cnt_d = loop_cnt_q;
      rst_cnt_d  = rst_cnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_LOAD;
               cycles_d   = '0;
               cause_d    = 2'd0;
               hist_d     = 2'd0;
               loop_cnt_d = '0;
            end
         end
         S_LOAD: begin
            rst_cnt_d = '0;
            state_d   = abort ? S_DONE : S_RST;
         end
         S_RST: begin
            if (abort) begin
               state_d = S_DONE;
            end else if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
               state_d = S_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         S_RUN: begin
            if (stop_now) begin
               state_d = S_DONE;
               cause_d = cause_now;
            end else begin
               cycles_d   = (cycles_q == '1) ? cycles_q : cycles_q + CYC_W'(1);
               pc_d1_d    = pc;
               pc_d2_d    = pc_d1_q;
               hist_d     = (hist_q == 2'd2) ? hist_q : hist_q + 2'd1;
               loop_cnt_d = loop_match ? loop_cnt_q + LH_W'(1) : '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cycles_q     <= '0;
         cause_q      <= 2'd0;
         hist_q       <= 2'd0;
         loop_cnt_q   <= '0;
         rst_cnt_q    <= '0;
         cpu_reload_q <= 1'b0;
         cpu_reset_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cycles_q     <= cycles_d;
         cause_q      <= cause_d;
         hist_q       <= hist_d;
         loop_cnt_q   <= loop_cnt_d;
         rst_cnt_q    <= rst_cnt_d;
         cpu_reload_q <= (state_d == S_LOAD);
         cpu_reset_q  <= (state_d == S_RST);
         busy_q       <= (state_d == S_LOAD) || (state_d == S_RST) || (state_d == S_RUN);
         done_q       <= (state_d == S_DONE);
      end
   end

   // History validity is tracked by hist_q, so the pc values themselves need no reset.
   always_ff @(posedge clk) begin
      pc_d1_q <= pc_d1_d;
      pc_d2_q <= pc_d2_d;
   end

   assign cpu_reload = cpu_reload_q;
   assign cpu_reset  = cpu_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign stop_cause = cause_q;
   assign cycles     = cycles_q;

endmodule

// File: tb/tb_hack_run_controller.sv
// Bench for hack_run_controller: a table-driven virtual CPU supplies pc, and a
// run-level model walks the same pc trajectory to predict stop cause, count and pc.
module tb_hack_run_controller;
   localparam int CYC_W        = 32;
   localparam int RESET_CYCLES = 1;
   localparam int LOOP_HITS    = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [CYC_W-1:0] max_cycles = '0;
   logic             bp_en = 1'b0;
   logic [14:0]      bp_addr = '0;
   logic             loop_en = 1'b0;
   logic [14:0]      pc;
   logic             cpu_reload, cpu_reset, cpu_en, busy, done;
   logic [1:0]       stop_cause;
   logic [CYC_W-1:0] cycles;

   logic [14:0] nxt [32];
   logic [14:0] vpc = 15'd0;
   int checks = 0;
   int errors = 0;

   hack_run_controller #(.CYC_W(CYC_W), .RESET_CYCLES(RESET_CYCLES), .LOOP_HITS(LOOP_HITS)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .max_cycles(max_cycles),
      .bp_en(bp_en), .bp_addr(bp_addr), .loop_en(loop_en), .pc(pc),
      .cpu_reload(cpu_reload), .cpu_reset(cpu_reset), .cpu_en(cpu_en), .busy(busy),
      .done(done), .stop_cause(stop_cause), .cycles(cycles));

   always #5 clk = ~clk;

   always @(posedge clk) if (cpu_en) vpc <= cpu_reset ? 15'd0 : nxt[vpc[4:0]];
   assign pc = vpc;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Walk the program instruction by instruction applying the stop rules.
   task automatic model(input int maxc, input bit bpe, input int bpa, input bit le,
                        input int abort_at, output int ecause, output int ecyc, output int epc);
      int p, hits;
      int hist[$];
      bit m;
      p = 0; hits = 0; ecause = -1; ecyc = -1; epc = -1;
      for (int k = 0; k < 5000; k++) begin
         m = le && (hist.size() >= 2) && (p == hist[hist.size()-2]);
         if (k == abort_at)                     ecause = 0;
         else if (bpe && p == bpa)              ecause = 2;
         else if (m && hits == LOOP_HITS - 1)   ecause = 3;
         else if (maxc != 0 && k == maxc)       ecause = 1;
         if (ecause >= 0) begin
            ecyc = k; epc = p;
            return;
         end
         hits = m ? hits + 1 : 0;
         hist.push_back(p);
         p = int'(nxt[p]);
      end
   endtask

   task automatic linear_table();
      for (int i = 0; i < 32; i++) nxt[i] = 15'((i + 1) % 32);
   endtask

   task automatic do_run(input string tag, input int maxc, input bit bpe, input int bpa,
                         input bit le, input int abort_at, input bit hold);
      int ecause, ecyc, epc, nrel, nrst;
      bit finished;
      max_cycles = CYC_W'(maxc); bp_en = bpe; bp_addr = 15'(bpa); loop_en = le;
      start = 1'b1;
      model(maxc, bpe, bpa, le, abort_at, ecause, ecyc, epc);
      nrel = 0; nrst = 0; finished = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         if (done) begin
            finished = 1'b1;
            break;
         end
         if (cpu_reload) begin
            nrel++;
            chk({tag, "_cyc_clear"}, cycles, 0);
         end
         if (cpu_reset) nrst++;
         if (!hold) start = 1'b0;
         abort = busy && !cpu_reload && !cpu_reset && abort_at >= 0 && int'(cycles) == abort_at;
      end
      start = 1'b0; abort = 1'b0;
      chk({tag, "_finished"}, finished, 1);
      chk({tag, "_cause"}, stop_cause, ecause);
      chk({tag, "_cycles"}, cycles, ecyc);
      chk({tag, "_stop_pc"}, vpc, epc);
      chk({tag, "_reloads"}, nrel, 1);
      chk({tag, "_rst_cycles"}, nrst, RESET_CYCLES);
   endtask

   initial begin
      int maxc, bpa, abort_at, r, hold_cyc;
      bit bpe, le, hold;
      linear_table();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_reload", cpu_reload, 0);
      chk("rst_cpu_reset", cpu_reset, 0);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_cause", stop_cause, 0);
      chk("rst_cycles", cycles, 0);
      reset = 1'b0;

      // Abort while idle is ignored
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("idle_abort_done", done, 0);
      chk("idle_abort_busy", busy, 0);

      // Budget of 5 on a straight-line program, then a fresh run
      do_run("budget5", 5, 1'b0, 0, 1'b0, -1, 1'b0);
      repeat (2) @(negedge clk);
      chk("done_hold", done, 1);
      chk("cycles_hold", cycles, 5);
      do_run("budget5_again", 5, 1'b0, 0, 1'b0, -1, 1'b1);

      // Abort in third RUN cycle, breakpoint at pc 0
      do_run("abort_run", 0, 1'b0, 0, 1'b0, 2, 1'b0);
      do_run("bp_zero", 0, 1'b1, 0, 1'b0, -1, 1'b0);

      // End-of-program tight loop between 14 and 15
      nxt[15] = 15'd14;
      do_run("bp14", 0, 1'b1, 14, 1'b0, 200, 1'b0);
      do_run("loop_end", 0, 1'b0, 0, 1'b1, 200, 1'b0);
      linear_table();

      // Abort during RST
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rstab_in_rst", cpu_reset, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("rstab_done", done, 1);
      chk("rstab_cause", stop_cause, 0);
      chk("rstab_cycles", cycles, 0);
      chk("rstab_cpu_reset", cpu_reset, 0);

      // Start and abort together in DONE: start wins, then abort in LOAD
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("startwins_reload", cpu_reload, 1);
      chk("startwins_done", done, 0);
      @(negedge clk);
      abort = 1'b0;
      chk("loadab_done", done, 1);
      chk("loadab_cause", stop_cause, 0);
      chk("loadab_cpu_reset", cpu_reset, 0);

      // Controller reset mid-run with start held
      max_cycles = '0; bp_en = 1'b0; loop_en = 1'b0;
      start = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrun_cycles", cycles, 3);
      reset = 1'b1;
      #1;
      chk("midrun_cpu_en", cpu_en, 0);
      @(negedge clk);
      chk("midrun_busy", busy, 0);
      chk("midrun_done", done, 0);
      chk("midrun_cpu_en2", cpu_en, 0);
      chk("midrun_cycles0", cycles, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("midrun_restart", cpu_reload, 1);
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("midrun_abort_done", done, 1);

      // Randomized programs and run configurations
      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < 32; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      nxt[i] = 15'((i + 1) % 32);
            else if (r < 85) nxt[i] = 15'(i);
            else             nxt[i] = 15'($urandom_range(0, 31));
         end
         maxc = $urandom_range(0, 40);
         bpe = 1'($urandom_range(0, 1));
         bpa = $urandom_range(0, 31);
         le = 1'($urandom_range(0, 1));
         hold = 1'($urandom_range(0, 1));
         abort_at = (maxc == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : -1;
         do_run($sformatf("rand%0d", it), maxc, bpe, bpa, le, abort_at, hold);
         hold_cyc = $urandom_range(0, 2);
         repeat (hold_cyc) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
